instr_mem_loadable: RTL and testbench
=====================================

// Module: instr_mem_loadable
// PURPOSE
//  Parametrised instruction memory for the single-cycle core: word-indexed fetch
//  port with a req/valid handshake and 1-cycle registered read latency. Adds:
//  - a streaming program-load port, so programs are loaded at runtime instead of fixed at elaboration
//  - a self-clear sequence after reset that fills every word with NOP
//  - misaligned and out-of-range fetch fault reporting
// PARAMETERS
//  INSTR_W  32            instruction word width (bits)
//  DEPTH    16            number of words; power of two, >=2; IDX_W = $clog2(DEPTH)
//  ADDR_W   64            fetch byte-address width
//  NOP      32'h00000013  fill value (addi x0,x0,0); also the value returned on fault
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        asynchronous, active-low reset
//  ld_start     in   1        begin load; honoured only in IDLE
//  ld_valid     in   1        ld_data valid this cycle
//  ld_data      in   INSTR_W  word to write at the current load pointer
//  ld_last      in   1        with ld_valid: this is the final word
//  perr_inject  in   1        with ld_valid: store an inverted parity bit (parity build only)
//  ld_ready     out  1        1 in LOAD
//  ld_done      out  1        1-cycle pulse when a load completes
//  fetch_req    in   1        fetch request
//  fetch_addr   in   ADDR_W   byte address
//  fetch_ready  out  1        1 in IDLE
//  fetch_valid  out  1        1-cycle pulse, the cycle after acceptance
//  fetch_instr  out  INSTR_W  fetched word
//  fetch_fault  out  1        qualifies fetch_valid: bad address
//  fetch_perr   out  1        qualifies fetch_valid: parity mismatch
//  busy         out  1        1 in CLEAR or LOAD
// BEHAVIOUR
//  States: CLEAR -> IDLE <-> LOAD.
//  Reset (rst=0), async:
//   - state=CLEAR, clr_cnt=0, ld_ptr=0
//   - fetch_valid/fault/perr=0, fetch_instr=0, ld_done=0
//  CLEAR:
//   - each cycle mem[clr_cnt]<=NOP and clr_cnt++
//   - after DEPTH cycles (last index DEPTH-1) go to IDLE
//   - busy=1, fetch_ready=0, ld_ready=0; ld_start and fetch_req ignored
//  IDLE: fetch_ready=1, busy=0.
//   - Accept = fetch_req & fetch_ready.
//   - Next cycle: fetch_valid=1 and fetch_instr=mem[fetch_addr[IDX_W+1:2]].
//   - Fault when fetch_addr[1:0]!=0 or fetch_addr>=DEPTH*4: fetch_fault=1, fetch_instr=NOP.
//   - Back-to-back accepts give one fetch_valid per cycle.
//   - With no accept, fetch_valid=0 and fetch_instr holds its last value.
//   - ld_start -> LOAD with ld_ptr=0.
//   - fetch_req and ld_start together: the fetch is accepted and reads pre-load
//     contents; LOAD is entered on the same edge.
//  LOAD: ld_ready=1, fetch_ready=0, busy=1.
//   - Each ld_valid writes mem[ld_ptr]<=ld_data, then ld_ptr++.
//   - Completes on a write with ld_last=1, or on the write to DEPTH-1:
//     ld_done pulses the next cycle and the state returns to IDLE.
//   - ld_ptr never wraps; unwritten words keep their prior contents.
//   - ld_start is ignored in LOAD.
//  Reset mid-load or mid-clear: restarts CLEAR; all contents become NOP.
//  Memory writes occur only in CLEAR and LOAD; there is no write-during-read hazard.
// CONFIGURATION
//  IMEM_PARITY_EN defined:
//   - each word stores an extra even-parity bit (^data)
//   - CLEAR writes the parity of NOP
//   - a LOAD write with perr_inject=1 stores the inverted parity bit
//   - a non-faulting fetch sets fetch_perr=1 if the stored parity != ^word
//  IMEM_PARITY_EN undefined:
//   - no parity storage; perr_inject is ignored; fetch_perr is tied 0
//  All ports exist in both builds.
// TESTING
//  1. Release rst: busy=1 for 16 cycles; then fetch 0x00..0x3C -> each returns
//     0x00000013, fault=0, valid one cycle after req.
//  2. Load 16 words, word2=0x0BA00193 -> ld_done pulses once after the 16th write;
//     fetch 0x08 -> 0x0BA00193.
//  3. Load 3 words, ld_last on the 3rd (word2=0x00D18633) -> ld_done;
//     fetch 0x08 -> 0x00D18633; fetch 0x0C..0x3C -> prior contents (NOP after fresh clear).
//  4. Fetch 0x06 -> fault=1, instr=NOP; fetch 0x40 -> fault=1; fetch 0x3C -> fault=0.
//  5. rst low while loading word 5 -> CLEAR restarts; afterwards all 16 words = NOP.
//     Also: ld_start with fetch_req in IDLE -> fetch returns the old word.
//  6. IMEM_PARITY_EN: load word4 with perr_inject=1 -> fetch 0x10 gives perr=1,
//     fetch 0x0C gives perr=0. Without the macro: perr=0 always.

Source files
------------

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: NOP self-clear after reset, streaming program load,
// registered fetch with fault reporting. Optional stored parity per word via IMEM_PARITY_EN.
module instr_mem_loadable #(
    parameter int                 INSTR_W = 32,
    parameter int                 DEPTH   = 16,
    parameter int                 ADDR_W  = 64,
    parameter logic [INSTR_W-1:0] NOP     = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld_start,
    input  logic               ld_valid,
    input  logic [INSTR_W-1:0] ld_data,
    input  logic               ld_last,
    input  logic               perr_inject,
    output logic               ld_ready,
    output logic               ld_done,
    input  logic               fetch_req,
    input  logic [ADDR_W-1:0]  fetch_addr,
    output logic               fetch_ready,
    output logic               fetch_valid,
    output logic [INSTR_W-1:0] fetch_instr,
    output logic               fetch_fault,
    output logic               fetch_perr,
    output logic               busy
);
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;

    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH * 4);

    function automatic logic parity_f(input logic [INSTR_W-1:0] data);
        return ^data;
    endfunction

    logic [1:0]         state_r;
    logic [IDX_W-1:0]   clr_cnt_r;
    logic [IDX_W-1:0]   ld_ptr_r;
    logic               ld_done_r;
    logic               fetch_valid_r;
    logic [INSTR_W-1:0] fetch_instr_r;
    logic               fetch_fault_r;
    logic               fetch_perr_r;
    logic [INSTR_W-1:0] mem_r [DEPTH];

    logic               wr_en_s;
    logic [IDX_W-1:0]   wr_idx_s;
    logic [INSTR_W-1:0] wr_data_s;
    logic               ld_end_s;
    logic               accept_s;
    logic               fault_s;
    logic [IDX_W-1:0]   rd_idx_s;
    logic               perr_s;

    assign ld_end_s = ld_valid & (ld_last | (ld_ptr_r == LAST_IDX));
    assign accept_s = fetch_req & (state_r == ST_IDLE);
    assign fault_s  = (fetch_addr[1:0] != 2'b00) | (fetch_addr >= ADDR_LIMIT);
    assign rd_idx_s = fetch_addr[IDX_W+1:2];

    // Single write port shared by the clear sweep and the load stream.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_idx_s  = '0;
        wr_data_s = NOP;
        case (state_r)
            ST_CLEAR: begin
                wr_en_s  = 1'b1;
                wr_idx_s = clr_cnt_r;
            end
            ST_LOAD: begin
                if (ld_valid) begin
                    wr_en_s   = 1'b1;
                    wr_idx_s  = ld_ptr_r;
                    wr_data_s = ld_data;
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            default: wr_en_s = 1'b0;
        endcase
    end

    // Data array; contents are defined by the post-reset clear sweep, not by reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_idx_s] <= wr_data_s;
        end
    end

`ifdef IMEM_PARITY_EN
    logic mem_par_r [DEPTH];
    logic wr_par_s;

    // Stored parity bit; a load can deliberately corrupt it for fault testing.
    always_comb begin
        wr_par_s = parity_f(NOP);
        if ((state_r == ST_LOAD) && ld_valid) begin
            wr_par_s = parity_f(ld_data) ^ perr_inject;
        end else begin
            wr_par_s = parity_f(NOP);
        end
    end

    // Parity array written alongside the data array.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_par_r[wr_idx_s] <= wr_par_s;
        end
    end

    assign perr_s = (mem_par_r[rd_idx_s] != parity_f(mem_r[rd_idx_s]));
`else
    logic unused_s;
    assign unused_s = perr_inject;
    assign perr_s   = 1'b0;
`endif

    // Control FSM: clear sweep, idle, load stream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_CLEAR;
            clr_cnt_r <= '0;
            ld_ptr_r  <= '0;
            ld_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    ld_done_r <= 1'b0;
                    clr_cnt_r <= clr_cnt_r + 1'b1;
                    if (clr_cnt_r == LAST_IDX) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_CLEAR;
                    end
                end
                ST_IDLE: begin
                    ld_done_r <= 1'b0;
                    if (ld_start) begin
                        state_r  <= ST_LOAD;
                        ld_ptr_r <= '0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (ld_end_s) begin
                        state_r   <= ST_IDLE;
                        ld_done_r <= 1'b1;
                    end else if (ld_valid) begin
                        ld_ptr_r  <= ld_ptr_r + 1'b1;
                        ld_done_r <= 1'b0;
                    end else begin
                        ld_done_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_CLEAR;
                    clr_cnt_r <= '0;
                    ld_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Registered fetch response; instruction holds when nothing is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_valid_r <= 1'b0;
            fetch_fault_r <= 1'b0;
            fetch_perr_r  <= 1'b0;
            fetch_instr_r <= '0;
        end else begin
            fetch_valid_r <= accept_s;
            fetch_fault_r <= accept_s & fault_s;
            fetch_perr_r  <= accept_s & ~fault_s & perr_s;
            if (accept_s) begin
                fetch_instr_r <= fault_s ? NOP : mem_r[rd_idx_s];
            end
        end
    end

    assign ld_ready    = (state_r == ST_LOAD);
    assign fetch_ready = (state_r == ST_IDLE);
    assign busy        = (state_r != ST_IDLE);
    assign ld_done     = ld_done_r;
    assign fetch_valid = fetch_valid_r;
    assign fetch_instr = fetch_instr_r;
    assign fetch_fault = fetch_fault_r;
    assign fetch_perr  = fetch_perr_r;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench for instr_mem_loadable: abstract memory model checked every cycle,
// plus literal expectations on selected fetches and load completions.
module tb_instr_mem_loadable;
    localparam logic [31:0] NOPW = 32'h0000_0013;
`ifdef IMEM_PARITY_EN
    localparam logic PERR_EXP = 1'b1;
`else
    localparam logic PERR_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ld_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_data = 32'h0;
    logic        ld_last = 1'b0;
    logic        perr_inject = 1'b0;
    logic        ld_ready;
    logic        ld_done;
    logic        fetch_req = 1'b0;
    logic [63:0] fetch_addr = 64'h0;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        fetch_fault;
    logic        fetch_perr;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    instr_mem_loadable dut (
        .clk(clk), .rst(rst),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .perr_inject(perr_inject), .ld_ready(ld_ready), .ld_done(ld_done),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_fault(fetch_fault),
        .fetch_perr(fetch_perr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- abstract model: 0=clear, 1=idle, 2=load ----------------
    int          m_mode;
    int          m_clr_left;
    int          m_ptr;
    logic [31:0] m_mem [16];
    logic        m_par [16];
    logic        m_valid, m_fault, m_perr, m_done;
    logic [31:0] m_instr;

    always @(posedge clk or negedge rst) begin : model
        int idx;
        if (!rst) begin
            m_mode = 0; m_clr_left = 16; m_ptr = 0;
            m_valid = 1'b0; m_fault = 1'b0; m_perr = 1'b0; m_done = 1'b0; m_instr = 32'h0;
            for (int i = 0; i < 16; i++) begin
                m_mem[i] = NOPW;
                m_par[i] = ^NOPW;
            end
        end else begin
            m_valid = 1'b0; m_fault = 1'b0; m_perr = 1'b0; m_done = 1'b0;
            if (m_mode == 1 && fetch_req) begin
                m_valid = 1'b1;
                if ((fetch_addr % 4) != 0 || fetch_addr >= 64) begin
                    m_fault = 1'b1;
                    m_instr = NOPW;
                end else begin
                    idx = int'(fetch_addr / 4);
                    m_instr = m_mem[idx];
`ifdef IMEM_PARITY_EN
                    m_perr = (m_par[idx] != ^m_mem[idx]);
`endif
                end
            end
            if (m_mode == 0) begin
                m_clr_left--;
                if (m_clr_left == 0) m_mode = 1;
            end else if (m_mode == 1) begin
                if (ld_start) begin m_mode = 2; m_ptr = 0; end
            end else if (ld_valid) begin
                m_mem[m_ptr] = ld_data;
                m_par[m_ptr] = (^ld_data) ^ perr_inject;
                if (ld_last || m_ptr == 15) begin
                    m_done = 1'b1;
                    m_mode = 1;
                end else begin
                    m_ptr++;
                end
            end
        end
    end

    // Every-cycle comparison against the model while out of reset.
    always @(negedge clk) begin
        if (rst) begin
            check("valid", fetch_valid, m_valid);
            check("fault", fetch_fault, m_fault);
            check("perr", fetch_perr, m_perr);
            check("instr", fetch_instr, m_instr);
            check("ld_done", ld_done, m_done);
            check("busy", busy, m_mode != 1);
            check("fetch_ready", fetch_ready, m_mode == 1);
            check("ld_ready", ld_ready, m_mode == 2);
        end
    end

    logic [31:0] words [16];

    task automatic wait_idle();
        int cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("busy_cycles", cyc, 32'd16);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b1);
        check("rst_valid", fetch_valid, 1'b0);
        check("rst_instr", fetch_instr, 32'h0);
        check("rst_done", ld_done, 1'b0);
        rst = 1'b1;
        wait_idle();
    endtask

    task automatic do_fetch(input string nm, input logic [63:0] a, input logic [31:0] ei,
                            input logic ef, input logic ep);
        fetch_req  = 1'b1;
        fetch_addr = a;
        @(negedge clk);
        fetch_req = 1'b0;
        check({nm, "_valid"}, fetch_valid, 1'b1);
        check({nm, "_instr"}, fetch_instr, ei);
        check({nm, "_fault"}, fetch_fault, ef);
        check({nm, "_perr"}, fetch_perr, ep);
    endtask

    task automatic do_load(input int n, input logic use_last, input int inj);
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            ld_valid    = 1'b1;
            ld_data     = words[i];
            ld_last     = use_last && (i == n - 1);
            perr_inject = (i == inj);
            @(negedge clk);
        end
        ld_valid = 1'b0; ld_last = 1'b0; perr_inject = 1'b0;
        check("load_done", ld_done, 1'b1);
        @(negedge clk);
        check("load_done_pulse", ld_done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: clear sweep then all words NOP
        do_reset();
        for (int a = 0; a < 64; a += 4) do_fetch("t1", 64'(a), NOPW, 1'b0, 1'b0);
        @(negedge clk);

        // 2: full 16-word load, completes on the last index
        for (int i = 0; i < 16; i++) words[i] = 32'h0010_0093 + 32'(i << 20);
        words[2] = 32'h0BA0_0193;
        do_load(16, 1'b0, -1);
        do_fetch("t2_w2", 64'h08, 32'h0BA0_0193, 1'b0, 1'b0);
        do_fetch("t2_w15", 64'h3C, 32'h0100_0093, 1'b0, 1'b0);

        // 3: short load on fresh clear, ld_last on third word
        do_reset();
        words[0] = 32'h0050_0093; words[1] = 32'h0070_0113; words[2] = 32'h00D1_8633;
        do_load(3, 1'b1, -1);
        do_fetch("t3_w2", 64'h08, 32'h00D1_8633, 1'b0, 1'b0);
        do_fetch("t3_w0", 64'h00, 32'h0050_0093, 1'b0, 1'b0);
        for (int a = 12; a < 64; a += 4) do_fetch("t3_rest", 64'(a), NOPW, 1'b0, 1'b0);

        // 4: address faults
        do_fetch("t4_mis", 64'h06, NOPW, 1'b1, 1'b0);
        do_fetch("t4_oor", 64'h40, NOPW, 1'b1, 1'b0);
        do_fetch("t4_edge", 64'h3C, NOPW, 1'b0, 1'b0);
        do_fetch("t4_high", 64'h8000_0000_0000_0000, NOPW, 1'b1, 1'b0);
        @(negedge clk);

        // 5: reset while loading word 5 restarts the clear
        for (int i = 0; i < 16; i++) words[i] = 32'hA000_0000 + 32'(i);
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ld_valid = 1'b1; ld_data = words[i];
            @(negedge clk);
        end
        ld_data = words[5];
        rst = 1'b0;
        repeat (2) @(negedge clk);
        ld_valid = 1'b0;
        rst = 1'b1;
        wait_idle();
        for (int a = 0; a < 64; a += 4) do_fetch("t5_clr", 64'(a), NOPW, 1'b0, 1'b0);

        // 5b: fetch and ld_start together read pre-load contents
        words[0] = 32'hCAFE_0001;
        do_load(1, 1'b1, -1);
        fetch_req = 1'b1; fetch_addr = 64'h0; ld_start = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0; ld_start = 1'b0;
        check("t5b_valid", fetch_valid, 1'b1);
        check("t5b_old", fetch_instr, 32'hCAFE_0001);
        check("t5b_ld_ready", ld_ready, 1'b1);
        ld_valid = 1'b1; ld_data = 32'h1234_5678; ld_last = 1'b1;
        @(negedge clk);
        ld_valid = 1'b0; ld_last = 1'b0;
        check("t5b_done", ld_done, 1'b1);
        @(negedge clk);
        do_fetch("t5b_new", 64'h0, 32'h1234_5678, 1'b0, 1'b0);

        // 6: injected parity error on word 4
        for (int i = 0; i < 5; i++) words[i] = 32'h0020_0213 + 32'(i << 8);
        words[4] = 32'h00A0_0213;
        do_load(5, 1'b1, 4);
        do_fetch("t6_bad", 64'h10, 32'h00A0_0213, 1'b0, PERR_EXP);
        do_fetch("t6_good", 64'h0C, 32'h0020_0513, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
